// File: rtl/mw_add_seq_pkg.sv
// ----------------------------------------------------------------------------
// mw_add_pkg : shared types and helpers for the sequential multi-word adder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mw_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement overflow: like-signed operands giving an opposite-signed result.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mw_add_seq_if.sv
// ----------------------------------------------------------------------------
// mw_add_seq_if : operand/result handshake bundle for mw_add_seq
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mw_add_seq_if #(
  parameter int N = 8,
  parameter int W = 4
);

  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] a;
  logic [N*W-1:0] b;
  logic           ci;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] sum;
  logic           co;
  logic           ovf;

  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, sum, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, sum, co, ovf
  );

endinterface

`default_nettype wire

// File: rtl/mw_add_seq_n_adder.sv
// ----------------------------------------------------------------------------
// n_adder : N-bit ripple adder with carry-in and carry-out
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module n_adder #(
  parameter int N = 8
) (
  input  wire logic [N-1:0] A,
  input  wire logic [N-1:0] B,
  input  wire logic         ci,
  output logic      [N-1:0] S,
  output logic              co
);

  assign {co, S} = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, ci};

endmodule

`default_nettype wire

// File: rtl/mw_add_seq.sv
// ----------------------------------------------------------------------------
// mw_add_seq : sequential N*W-bit adder, one N-bit chunk per cycle, LSB first
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mw_add_seq
  import mw_add_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 4
) (
  input wire logic   clk,
  input wire logic   rst,
  mw_add_seq_if.slave bus
);

  localparam int               IDX_W    = $clog2(W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [N*W-1:0]   a_q;
  logic [N*W-1:0]   b_q;
  logic [N-1:0]     sum_q [W];
  logic             co_q;
  logic             ovf_q;

  logic [N-1:0]     a_chunk [W];
  logic [N-1:0]     b_chunk [W];
  logic [N-1:0]     chunk_s;
  logic             chunk_co;

  for (genvar g = 0; g < W; g++) begin : g_chunk
    assign a_chunk[g]          = a_q[g*N +: N];
    assign b_chunk[g]          = b_q[g*N +: N];
    assign bus.sum[g*N +: N]   = sum_q[g];
  end

  n_adder #(.N(N)) u_n_adder (
    .A  (a_chunk[idx_q]),
    .B  (b_chunk[idx_q]),
    .ci (carry_q),
    .S  (chunk_s),
    .co (chunk_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < W; i++) sum_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.ci;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[idx_q] <= chunk_s;
          carry_q      <= chunk_co;
          // idx holds at the last chunk rather than wrapping; IDLE re-zeroes it.
          if (idx_q == LAST_IDX) begin
            co_q    <= chunk_co;
            ovf_q   <= signed_ovf(a_q[N*W-1], b_q[N*W-1], chunk_s[N-1]);
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.co        = co_q;
  assign bus.ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mw_add_seq.sv
// ----------------------------------------------------------------------------
// tb_mw_add_seq : directed vector table, corner sequences and random ops for mw_add_seq
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mw_add_seq;

  localparam int N = 8;
  localparam int W = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] exp_sum;
    logic        exp_co;
    logic        exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mw_add_seq_if #(.N(N), .W(W)) bus ();

  mw_add_seq #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operation, measure latency, optionally stall the result, then release it.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                        input int stall,
                        output logic [31:0] s, output logic c, output logic o);
    int k;
    bus.a        = a;
    bus.b        = b;
    bus.ci       = ci;
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      tick();
      k++;
    end
    if (!bus.in_ready) chk("accept_timeout", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.ci       = 1'($urandom);
    chk("busy_after_accept", 64'({bus.in_ready, bus.out_valid}), 64'd0);
    k = 0;
    while (!bus.out_valid && k < 20) begin
      tick();
      k++;
    end
    chk("latency", 64'(k), 64'(W));
    s = bus.sum;
    c = bus.co;
    o = bus.ovf;
    repeat (stall) begin
      tick();
      chk("hold_stable", 64'({bus.out_valid, bus.in_ready, bus.co, bus.ovf, bus.sum}),
          64'({1'b1, 1'b0, c, o, s}));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("released", 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [8];
    logic [31:0] s;
    logic        c;
    logic        o;
    logic [32:0] m33;
    longint      ss;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rci;

    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[7] = '{32'h7FFF_FFFE, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b0, 1'b1};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.ci        = 1'b0;
    rst           = 1'b1;
    repeat (2) tick();
    chk("rst_in_ready",  64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_results",   64'({bus.co, bus.ovf, bus.sum}), 64'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 64'(bus.in_ready), 64'd1);

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].ci, i % 3, s, c, o);
      chk($sformatf("vec%0d_sum", i), 64'(s), 64'(vecs[i].exp_sum));
      chk($sformatf("vec%0d_co", i),  64'(c), 64'(vecs[i].exp_co));
      chk($sformatf("vec%0d_ovf", i), 64'(o), 64'(vecs[i].exp_ovf));
    end

    // Result held in DONE while a new request waits; second op only after handshake
    bus.a = 32'd1; bus.b = 32'd2; bus.ci = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.a = 32'd100; bus.b = 32'd200;
    repeat (W) tick();
    chk("stall_valid", 64'(bus.out_valid), 64'd1);
    repeat (5) begin
      tick();
      chk("stall_hold", 64'({bus.out_valid, bus.in_ready, bus.co, bus.ovf, bus.sum}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 32'd3}));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("stall_idle_ready", 64'({bus.in_ready, bus.out_valid}), 64'b10);
    tick();
    bus.in_valid = 1'b0;
    chk("stall_second_taken", 64'(bus.in_ready), 64'd0);
    repeat (W - 1) tick();
    chk("stall_second_early", 64'(bus.out_valid), 64'd0);
    tick();
    chk("stall_second_sum", 64'({bus.out_valid, bus.sum}), 64'({1'b1, 32'd300}));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Reset while the third chunk is being added
    bus.a = 32'hFFFF_FFFF; bus.b = 32'h0000_0001; bus.ci = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_results", 64'({bus.co, bus.ovf, bus.sum}), 64'd0);
    rst = 1'b0;
    #1;
    chk("midrst_rel_ready", 64'(bus.in_ready), 64'd1);
    run_op(32'd5, 32'd10, 1'b1, 1, s, c, o);
    chk("midrst_next_op", 64'({c, o, s}), 64'({1'b0, 1'b0, 32'd16}));

    // Random operations with result stalls
    for (int i = 0; i < 200; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rci = 1'($urandom);
      if (i % 10 == 0) ra = {1'b0, 31'h7FFF_FFFF} - 32'($urandom_range(0, 3));
      m33 = {1'b0, ra} + {1'b0, rb} + {32'd0, rci};
      ss  = longint'($signed(ra)) + longint'($signed(rb)) + longint'(rci);
      run_op(ra, rb, rci, int'($urandom_range(0, 3)), s, c, o);
      chk("rand_cosum", 64'({c, s}), 64'(m33));
      chk("rand_ovf", 64'(o), 64'((ss > 64'sd2147483647) || (ss < -64'sd2147483648)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
